// File: rtl/ws2812_stream_tx.sv
// WS2812B frame transmitter: LED_COUNT pixels from a valid/ready stream, sent MSB first.
// Define WS2812_RGBW_EN for 32-bit {G,R,B,W} pixels (SK6812RGBW); default is 24-bit {G,R,B}.
`timescale 1ns/1ps
module ws2812_stream_tx #(
   parameter int unsigned LED_COUNT  = 8,
   parameter int unsigned T0H        = 4,
   parameter int unsigned T1H        = 8,
   parameter int unsigned TBIT       = 15,
   parameter int unsigned RES_CYCLES = 720,
`ifdef WS2812_RGBW_EN
   localparam int unsigned PW        = 32
`else
   localparam int unsigned PW        = 24
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [PW-1:0] pix_data,
   input  logic          pix_valid,
   output logic          pix_ready,
   output logic          busy,
   output logic          done,
   output logic          underrun,
   output logic          sig1
);

   localparam int unsigned NW = $clog2(LED_COUNT + 1);
   localparam int unsigned BW = $clog2(PW);
   localparam int unsigned CW = $clog2(TBIT);
   localparam int unsigned RW = $clog2(RES_CYCLES + 1);

   localparam logic [NW-1:0] LED_N    = NW'(LED_COUNT);
   localparam logic [BW-1:0] BIT_TOP  = BW'(PW - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(TBIT - 1);
   localparam logic [CW-1:0] T0H_C    = CW'(T0H);
   localparam logic [CW-1:0] T1H_C    = CW'(T1H);
   localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES - 1);
   localparam logic [RW-1:0] RES_ONE  = RW'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT1, S_SEND, S_LATCH} state_t;

   state_t          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            und_q, und_d;
   logic            sig1_q, sig1_d;
   logic            full_q, full_d;
   logic [PW-1:0]   buf_q, buf_d;
   logic [PW-1:0]   shift_q, shift_d;
   logic [NW-1:0]   req_q, req_d;
   logic [NW-1:0]   sent_q, sent_d;
   logic [BW-1:0]   bit_idx_q, bit_idx_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [RW-1:0]   res_q, res_d;
   logic            hs, load, enter_latch, discard;

   assign pix_ready = busy_q & ~full_q & (req_q < LED_N);
   assign hs        = pix_valid & pix_ready;
   assign busy      = busy_q;
   assign done      = done_q;
   assign underrun  = und_q;
   assign sig1      = sig1_q;

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      und_d       = und_q;
      full_d      = full_q;
      buf_d       = buf_q;
      shift_d     = shift_q;
      req_d       = req_q;
      sent_d      = sent_q;
      bit_idx_d   = bit_idx_q;
      cyc_d       = cyc_q;
      res_d       = res_q;
      load        = 1'b0;
      enter_latch = 1'b0;
      discard     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT1;
               busy_d  = 1'b1;
               und_d   = 1'b0;
               req_d   = '0;
               sent_d  = '0;
            end
         end
         S_WAIT1: begin
            if (full_q) load = 1'b1;
         end
         S_SEND: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (bit_idx_q == '0) begin
                  if (sent_q == LED_N) begin
                     enter_latch = 1'b1;
                  end else if (full_q) begin
                     load = 1'b1;
                  end else begin
                     und_d       = 1'b1;
                     enter_latch = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q - 1'b1;
                  shift_d   = {shift_q[PW-2:0], 1'b0};
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_LATCH: begin
            // Down-counter: done is raised one cycle early so its register lands on the last gap cycle.
            if (res_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               discard = 1'b1;
            end else begin
               res_d  = res_q - 1'b1;
               done_d = (res_q == RES_ONE);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         state_d   = S_SEND;
         shift_d   = buf_q;
         bit_idx_d = BIT_TOP;
         cyc_d     = '0;
         sent_d    = sent_q + 1'b1;
         full_d    = 1'b0;
      end
      if (enter_latch) begin
         state_d = S_LATCH;
         res_d   = RES_LAST;
         done_d  = (RES_CYCLES == 1);
      end
      // A handshake in the load cycle refills the buffer, so full stays set.
      if (hs) begin
         buf_d  = pix_data;
         full_d = 1'b1;
         req_d  = req_q + 1'b1;
      end
      if (discard) full_d = 1'b0;

      sig1_d = (state_d == S_SEND) && (cyc_d < (shift_d[PW-1] ? T1H_C : T0H_C));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         und_q     <= 1'b0;
         sig1_q    <= 1'b0;
         full_q    <= 1'b0;
         buf_q     <= '0;
         shift_q   <= '0;
         req_q     <= '0;
         sent_q    <= '0;
         bit_idx_q <= '0;
         cyc_q     <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         und_q     <= und_d;
         sig1_q    <= sig1_d;
         full_q    <= full_d;
         buf_q     <= buf_d;
         shift_q   <= shift_d;
         req_q     <= req_d;
         sent_q    <= sent_d;
         bit_idx_q <= bit_idx_d;
         cyc_q     <= cyc_d;
         res_q     <= res_d;
      end
   end

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Scoreboard bench for ws2812_stream_tx: instance A (2 LEDs) is pulse/done scoreboarded,
// instance B (3 LEDs) exercises underrun. Honours WS2812_RGBW_EN for the pixel width.
`timescale 1ns/1ps
module tb_ws2812_stream_tx;
`ifdef WS2812_RGBW_EN
   localparam int PW = 32;
   localparam logic [PW-1:0] PX0 = 32'h000000FF;
   localparam logic [PW-1:0] PX1 = 32'h00AA55C3;
   localparam logic [PW-1:0] PX2 = 32'h12345678;
   localparam logic [PW-1:0] PX3 = 32'hF0F00F0F;
`else
   localparam int PW = 24;
   localparam logic [PW-1:0] PX0 = 24'hFF0000;
   localparam logic [PW-1:0] PX1 = 24'h00AA55;
   localparam logic [PW-1:0] PX2 = 24'h123456;
   localparam logic [PW-1:0] PX3 = 24'hF0F00F;
`endif
   localparam int T0H = 4, T1H = 8, TBIT = 15, RES = 720;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start_a, start_b, valid_a, valid_b;
   logic [PW-1:0] data_a, data_b;
   logic          ready_a, busy_a, done_a, und_a, sig_a;
   logic          ready_b, busy_b, done_b, und_b, sig_b;

   ws2812_stream_tx #(.LED_COUNT(2), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RES_CYCLES(RES)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .pix_data(data_a), .pix_valid(valid_a),
      .pix_ready(ready_a), .busy(busy_a), .done(done_a), .underrun(und_a), .sig1(sig_a));

   ws2812_stream_tx #(.LED_COUNT(3), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RES_CYCLES(RES)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .pix_data(data_b), .pix_valid(valid_b),
      .pix_ready(ready_b), .busy(busy_b), .done(done_b), .underrun(und_b), .sig1(sig_b));

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   logic [PW-1:0] pq_a[$];
   logic [PW-1:0] pq_b[$];
   int            exp_w[$];
   int            exp_done[$];

   // Pixel sources: present queue head, pop when the upcoming edge will complete a handshake.
   initial begin
      valid_a = 1'b0; data_a = '0;
      forever begin
         @(negedge clk);
         valid_a = (pq_a.size() > 0);
         if (pq_a.size() > 0) data_a = pq_a[0];
         #1;
         if (valid_a && ready_a && pq_a.size() > 0) pq_a.delete(0);
      end
   end
   initial begin
      valid_b = 1'b0; data_b = '0;
      forever begin
         @(negedge clk);
         valid_b = (pq_b.size() > 0);
         if (pq_b.size() > 0) data_b = pq_b[0];
         #1;
         if (valid_b && ready_b && pq_b.size() > 0) pq_b.delete(0);
      end
   end

   // Monitor A: pulse widths against the scoreboard; gapless bit period inside a frame.
   bit mon_en = 1'b0;
   bit prev_a = 1'b0;
   int rise_c = -100000;
   always @(negedge clk) begin
      if (mon_en) begin
         if (sig_a && !prev_a) begin
            if (cyc - rise_c < 2 * TBIT) check("bit_period", cyc - rise_c, TBIT);
            rise_c = cyc;
         end
         if (!sig_a && prev_a) check("pulse_width", cyc - rise_c, (exp_w.size() > 0) ? exp_w.pop_front() : 0);
      end
      prev_a = sig_a;
   end

   int done_cnt_a = 0;
   always @(negedge clk) begin
      if (done_a) begin
         done_cnt_a++;
         check("done_time", cyc, (exp_done.size() > 0) ? exp_done.pop_front() : -1);
      end
   end

   task automatic push_bits(input logic [PW-1:0] p);
      for (int i = PW - 1; i >= 0; i--) exp_w.push_back(p[i] ? T1H : T0H);
   endtask

   task automatic frame_a(input logic [PW-1:0] p0, input logic [PW-1:0] p1, output int s);
      @(negedge clk);
      pq_a.push_back(p0);
      pq_a.push_back(p1);
      push_bits(p0);
      push_bits(p1);
      s = cyc;
      exp_done.push_back(s + 2 + 2 * PW * TBIT + RES);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int limit);
      for (int i = 0; i < limit && exp_done.size() > 0; i++) @(negedge clk);
      check("done_seen", exp_done.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int s, dc, highs, dfirst;

   initial begin
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_a", {sig_a, busy_a, ready_a, done_a, und_a}, 0);
      check("reset_b", {sig_b, busy_b, ready_b, done_b, und_b}, 0);
      rst = 1'b0;

      // Abort mid-SEND with a 3-cycle reset.
      @(negedge clk);
      pq_a.push_back(PX0);
      pq_a.push_back(PX1);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (50) @(negedge clk);
      check("abort_pre_busy", busy_a, 1);
      dc = done_cnt_a;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pq_a.delete();
         check("abort_outputs", {sig_a, busy_a, ready_a}, 0);
      end
      rst = 1'b0;
      repeat (RES + 100) @(negedge clk);
      check("abort_no_done", done_cnt_a, dc);
      mon_en = 1'b1;

      // Normal frame: ready handshake timing around the first load.
      frame_a(PX0, PX1, s);
      check("busy_after_start", busy_a, 1);
      check("ready_wait1", ready_a, 1);
      @(negedge clk);
      check("ready_full", ready_a, 0);
      check("sig_low_before_load", sig_a, 0);
      @(negedge clk);
      check("ready_after_load", ready_a, 1);
      check("first_high", sig_a, 1);
      wait_done_a(3 * PW * TBIT + RES);
      repeat (2) @(negedge clk);
      check("idle_after_done", {busy_a, done_a, sig_a}, 0);

      // Start pulses during SEND and LATCH must not disturb the frame.
      frame_a(PX2, PX3, s);
      repeat (100) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2 * PW * TBIT) @(negedge clk);
      check("in_latch", {busy_a, sig_a}, 2'b10);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done_a(3 * PW * TBIT + RES);
      repeat (60) @(negedge clk);
      check("no_restart", busy_a, 0);

      // Underrun: only two of three pixels supplied.
      @(negedge clk);
      pq_b.push_back(PX0);
      pq_b.push_back(PX1);
      s = cyc;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      repeat (2 * PW * TBIT + 1) @(negedge clk);
      check("und_before", und_b, 0);
      @(negedge clk);
      check("und_set", und_b, 1);
      check("und_sig_low", sig_b, 0);
      highs = 0;
      dfirst = -1;
      for (int i = 0; i < RES + 10 && dfirst < 0; i++) begin
         @(negedge clk);
         if (sig_b) highs++;
         if (done_b) dfirst = cyc - s;
      end
      check("und_latch_highs", highs, 0);
      check("und_done_time", dfirst, 2 + 2 * PW * TBIT + RES);
      check("und_sticky", und_b, 1);
      repeat (3) @(negedge clk);

      // Full frame on B: start clears underrun.
      pq_b.push_back(PX0);
      pq_b.push_back(PX1);
      pq_b.push_back(PX2);
      s = cyc;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      check("und_cleared", und_b, 0);
      dfirst = -1;
      for (int i = 0; i < 3 * PW * TBIT + RES + 50 && dfirst < 0; i++) begin
         @(negedge clk);
         if (done_b) dfirst = cyc - s;
      end
      check("b_done_time", dfirst, 2 + 3 * PW * TBIT + RES);
      check("b_no_underrun", und_b, 0);

      repeat (5) @(negedge clk);
      check("pending_bits", exp_w.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ws2812_stream_tx.md
Name: ws2812_stream_tx

Overview:
Parametrised WS2812B serial LED driver that transmits a frame of LED_COUNT pixels supplied by an upstream pixel source over a valid/ready stream. Each pixel is sent in GRB order, MSB first. Bit timing and the latch (reset) gap are set by cycle-count parameters, so the block is not tied to a 12 MHz clock. It sits between the frame/pattern logic and the LED data pin (sig1), and replaces fixed-pattern, free-running generation with host-triggered frames carrying real data.

Parameters:
LED_COUNT, 8, pixels per frame (>=1)
T0H, 4, high cycles for a '0' bit (333 ns at 12 MHz)
T1H, 8, high cycles for a '1' bit (667 ns at 12 MHz)
TBIT, 15, total cycles per bit (1.25 us at 12 MHz); require T0H < T1H < TBIT
RES_CYCLES, 720, low cycles appended after the frame (60 us at 12 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle frame request; honoured only in IDLE
pix_data  in  PW  pixel {G,R,B}; PW=24 (32 with the optional feature)
pix_valid  in  1  pix_data valid
pix_ready  out  1  block accepts pixel this cycle when pix_valid=1
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at the end of the latch gap
underrun  out  1  sticky error; cleared by the next accepted start
sig1  out  1  registered WS2812B data line

Behaviour:
- Reset: all outputs 0; state IDLE; holding buffer empty; counters 0. rst in any state aborts immediately; sig1 is low the next cycle.
- Holding buffer: one PW-bit register plus a full flag.
  - pix_ready = busy & ~full & (pixels_requested < LED_COUNT).
  - A handshake (pix_valid & pix_ready) sets full and increments pixels_requested.
- States:
  - IDLE: sig1=0. On start, clear underrun, clear counts and go to WAIT1.
  - WAIT1: wait with no timeout until full=1. Then move the buffer into the shift register, clear full, and go to SEND.
  - SEND: bit counter runs PW-1..0; cycle counter runs 0..TBIT-1. sig1=1 while cycle < (bit ? T1H : T0H), otherwise 0.
    - First sig1 high occurs the cycle after the shift-register load.
    - At cycle TBIT-1 of bit 0: if pixels_sent == LED_COUNT, go to LATCH.
    - Else if full, load the next pixel back-to-back with no gap cycle.
    - Else set underrun and go to LATCH, aborting the frame.
  - LATCH: sig1=0 for exactly RES_CYCLES cycles. On the last cycle pulse done, drop busy, discard any buffered pixel, and go to IDLE.
- start while busy is ignored.
- A handshake and a buffer-to-shift load in the same cycle are legal: full stays 1.
- Frame length is exactly LED_COUNT*PW*TBIT cycles of SEND when there is no underrun.
- Counter widths use $clog2 of their maximum value + 1. There must be no wrap-around within legal parameters.

Optional Feature:
WS2812_RGBW_EN
- Defined: PW=32 and pixels are sent {G,R,B,W} (SK6812RGBW), 32 bits per pixel. All other timing is unchanged.
- Undefined: PW=24 and the W channel does not exist.

Test Plan:
- Reset: hold rst 3 cycles mid-SEND -> sig1=0, busy=0, pix_ready=0 the next cycle, and no done pulse.
- Single frame with LED_COUNT=2 and pixels 0xFF0000, 0x00AA55, always valid:
  - First 8 bits show high widths of 8 cycles, then 4-cycle highs per bit pattern, each bit 15 cycles.
  - 720 low cycles, then done=1 for one cycle at cycle 1+2*24*15+720 after start (±1 fixed pipeline, documented).
- Back-to-back pixels: gapless transitions between the pixel 1 and pixel 2 bit periods; pix_ready reasserts the cycle after the load.
- Underrun: LED_COUNT=3, withhold the third pixel -> after pixel 2, underrun=1 and sig1 low for 720 cycles, then done. The next start clears underrun.
- start ignored: pulse start during SEND -> no change to frame length or done timing.
- WS2812_RGBW_EN: pixel 0x000000FF -> 24 '0' bits (4-cycle highs) then 8 '1' bits (8-cycle highs).
